// File: rtl/elink_rx_if.sv
// E-link receive deframer bus: byte input side, word FIFO pop side and status.
interface elink_rx_if #(
    parameter int DATA_IN_WIDTH  = 10,
    parameter int DATA_OUT_WIDTH = 18
);
    logic [DATA_IN_WIDTH-1:0]  din;
    logic                      din_valid;
    logic                      fifoFLUSH;
    logic                      rd_en;
    logic [DATA_OUT_WIDTH-1:0] dout;
    logic                      doutRdy;
    logic                      empty;
    logic                      full;
    logic                      prog_full;
    logic                      err_proto;
    logic                      err_ovf;

    // Producer of bytes / consumer of words (link side or bench).
    modport master (
        output din, din_valid, fifoFLUSH, rd_en,
        input  dout, doutRdy, empty, full, prog_full, err_proto, err_ovf
    );

    // The deframer itself.
    modport slave (
        input  din, din_valid, fifoFLUSH, rd_en,
        output dout, doutRdy, empty, full, prog_full, err_proto, err_ovf
    );
endinterface

// File: rtl/elink_rx_deframer.sv
// E-link receive deframer: pairs 10-bit coded bytes into 18-bit coded words
// (SOP / data / EOP), discards comma idles, flags illegal code sequences and
// buffers the words in a single-clock FIFO with registered status flags.
module elink_rx_deframer #(
    parameter int DATA_IN_WIDTH    = 10,
    parameter int DATA_OUT_WIDTH   = 18,
    parameter int FIFO_DEPTH       = 16,
    parameter int PROG_FULL_THRESH = 12
) (
    input  logic       clk,
    input  logic       rst,
    elink_rx_if.slave  bus
);
    localparam int PW = DATA_IN_WIDTH - 2;
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [1:0] CODE_DATA  = 2'b00;
    localparam logic [1:0] CODE_EOP   = 2'b01;
    localparam logic [1:0] CODE_SOP   = 2'b10;
    localparam logic [1:0] CODE_COMMA = 2'b11;

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_PROG = CW'(PROG_FULL_THRESH);

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_GOT_COMMA   = 3'd1,
        ST_FRAME       = 3'd2,
        ST_GOT_DATA_HI = 3'd3,
        ST_GOT_EOP_HI  = 3'd4
    } state_t;

    // ---------------- deframer ----------------
    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [PW-1:0]             r_hi;
    logic [PW-1:0]             w_hi_nxt;
    logic                      r_in_frame;
    logic                      w_in_frame_nxt;
    logic                      r_err_proto;
    logic                      w_err;
    logic                      w_wr_en;
    logic [DATA_OUT_WIDTH-1:0] w_wr_word;
    logic [1:0]                w_code;
    logic [PW-1:0]             w_payload;

    assign w_code    = bus.din[DATA_IN_WIDTH-1 -: 2];
    assign w_payload = bus.din[PW-1:0];

    // Next-state / pair assembly: decide on each valid byte what to latch, write or flag.
    always_comb begin
        w_state_nxt    = r_state;
        w_hi_nxt       = r_hi;
        w_in_frame_nxt = r_in_frame;
        w_err          = 1'b0;
        w_wr_en        = 1'b0;
        w_wr_word      = {CODE_DATA, r_hi, w_payload};
        if (bus.din_valid) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_code == CODE_COMMA) begin
                        w_hi_nxt    = w_payload;
                        w_state_nxt = ST_GOT_COMMA;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                ST_GOT_COMMA: begin
                    case (w_code)
                        CODE_SOP: begin
                            // A new SOP while still in a frame means the previous
                            // frame was truncated; the new frame is still accepted.
                            w_err          = r_in_frame;
                            w_wr_en        = 1'b1;
                            w_wr_word      = {CODE_SOP, r_hi, w_payload};
                            w_in_frame_nxt = 1'b1;
                            w_state_nxt    = ST_FRAME;
                        end
                        CODE_COMMA: begin
                            if (r_in_frame) begin
                                w_state_nxt = ST_FRAME;
                            end else begin
                                w_hi_nxt = w_payload;
                            end
                        end
                        default: begin
                            w_err          = 1'b1;
                            w_in_frame_nxt = 1'b0;
                            w_state_nxt    = ST_IDLE;
                        end
                    endcase
                end
                ST_FRAME: begin
                    case (w_code)
                        CODE_DATA: begin
                            w_hi_nxt    = w_payload;
                            w_state_nxt = ST_GOT_DATA_HI;
                        end
                        CODE_EOP: begin
                            w_hi_nxt    = w_payload;
                            w_state_nxt = ST_GOT_EOP_HI;
                        end
                        CODE_COMMA: begin
                            w_hi_nxt    = w_payload;
                            w_state_nxt = ST_GOT_COMMA;
                        end
                        default: begin
                            w_err          = 1'b1;
                            w_in_frame_nxt = 1'b0;
                            w_state_nxt    = ST_IDLE;
                        end
                    endcase
                end
                ST_GOT_DATA_HI: begin
                    if (w_code == CODE_DATA) begin
                        w_wr_en     = 1'b1;
                        w_wr_word   = {CODE_DATA, r_hi, w_payload};
                        w_state_nxt = ST_FRAME;
                    end else begin
                        w_err          = 1'b1;
                        w_in_frame_nxt = 1'b0;
                        w_state_nxt    = ST_IDLE;
                    end
                end
                ST_GOT_EOP_HI: begin
                    if (w_code == CODE_COMMA) begin
                        w_wr_en   = 1'b1;
                        w_wr_word = {CODE_EOP, r_hi, w_payload};
                    end else begin
                        w_err = 1'b1;
                    end
                    w_in_frame_nxt = 1'b0;
                    w_state_nxt    = ST_IDLE;
                end
                default: begin
                    w_in_frame_nxt = 1'b0;
                    w_state_nxt    = ST_IDLE;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Deframer state, latched high byte, frame flag and the protocol error pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_hi        <= '0;
            r_in_frame  <= 1'b0;
            r_err_proto <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hi        <= w_hi_nxt;
            r_in_frame  <= w_in_frame_nxt;
            r_err_proto <= w_err;
        end
    end

    // ---------------- word FIFO ----------------
    logic [DATA_OUT_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]             r_wptr;
    logic [AW-1:0]             r_rptr;
    logic [CW-1:0]             r_count;
    logic [CW-1:0]             w_count_nxt;
    logic [DATA_OUT_WIDTH-1:0] r_dout;
    logic                      r_dout_rdy;
    logic                      r_empty;
    logic                      r_full;
    logic                      r_prog_full;
    logic                      r_err_ovf;
    logic                      w_rd_ok;
    logic                      w_wr_ok;
    logic                      w_ovf;
    logic                      w_full_now;

    // Push/pop legality: a write on a full FIFO only lands if a read frees the head slot.
    always_comb begin
        w_full_now = (r_count == CNT_FULL);
        w_rd_ok    = 1'b0;
        w_wr_ok    = 1'b0;
        w_ovf      = 1'b0;
        if (!bus.fifoFLUSH) begin
            w_rd_ok = bus.rd_en && (r_count != CNT_ZERO);
            w_wr_ok = w_wr_en && (!w_full_now || w_rd_ok);
            w_ovf   = w_wr_en && w_full_now && !w_rd_ok;
        end else begin
            w_rd_ok = 1'b0;
        end
    end

    // Occupancy after this edge; drives the registered status flags.
    always_comb begin
        w_count_nxt = r_count;
        if (bus.fifoFLUSH) begin
            w_count_nxt = CNT_ZERO;
        end else if (w_wr_ok && !w_rd_ok) begin
            w_count_nxt = r_count + CNT_ONE;
        end else if (w_rd_ok && !w_wr_ok) begin
            w_count_nxt = r_count - CNT_ONE;
        end else begin
            w_count_nxt = r_count;
        end
    end

    // Word storage; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (rst && w_wr_ok) begin
            r_mem[r_wptr] <= w_wr_word;
        end
    end

    // Pointers, occupancy, registered read port, status flags and sticky overflow.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= CNT_ZERO;
            r_dout      <= '0;
            r_dout_rdy  <= 1'b0;
            r_empty     <= 1'b1;
            r_full      <= 1'b0;
            r_prog_full <= 1'b0;
            r_err_ovf   <= 1'b0;
        end else begin
            r_count     <= w_count_nxt;
            r_empty     <= (w_count_nxt == CNT_ZERO);
            r_full      <= (w_count_nxt == CNT_FULL);
            r_prog_full <= (w_count_nxt >= CNT_PROG);
            r_dout_rdy  <= w_rd_ok;
            if (bus.fifoFLUSH) begin
                r_wptr    <= '0;
                r_rptr    <= '0;
                r_err_ovf <= 1'b0;
            end else begin
                if (w_wr_ok) begin
                    r_wptr <= r_wptr + PTR_ONE;
                end
                if (w_rd_ok) begin
                    r_rptr <= r_rptr + PTR_ONE;
                    r_dout <= r_mem[r_rptr];
                end
                if (w_ovf) begin
                    r_err_ovf <= 1'b1;
                end
            end
        end
    end

    assign bus.dout      = r_dout;
    assign bus.doutRdy   = r_dout_rdy;
    assign bus.empty     = r_empty;
    assign bus.full      = r_full;
    assign bus.prog_full = r_prog_full;
    assign bus.err_proto = r_err_proto;
    assign bus.err_ovf   = r_err_ovf;
endmodule

// File: tb/tb_elink_rx_deframer.sv
// Testbench for elink_rx_deframer: directed scenarios plus a randomized byte
// stream, all checked against a pair-table reference model with a word queue.
module tb_elink_rx_deframer;
    localparam int DIW   = 10;
    localparam int DOW   = 18;
    localparam int DEPTH = 16;
    localparam int PFT   = 12;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    elink_rx_if #(.DATA_IN_WIDTH(DIW), .DATA_OUT_WIDTH(DOW)) bus ();

    elink_rx_deframer #(
        .DATA_IN_WIDTH(DIW), .DATA_OUT_WIDTH(DOW),
        .FIFO_DEPTH(DEPTH), .PROG_FULL_THRESH(PFT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- reference model ----------------
    // Pending high byte (if any) plus frame flag; words kept in a queue.
    bit              m_have_hi;
    logic [1:0]      m_hc;
    logic [7:0]      m_hi;
    bit              m_in_frame;
    logic [DOW-1:0]  m_q[$];
    logic [DOW-1:0]  exp_dout;
    logic            exp_rdy, exp_err, exp_ovf;

    localparam logic [23:0] RESET_VEC = {18'h00000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    function automatic logic [23:0] obs_vec();
        return {bus.dout, bus.doutRdy, bus.empty, bus.full, bus.prog_full, bus.err_proto, bus.err_ovf};
    endfunction

    function automatic logic [23:0] exp_vec();
        int n;
        n = m_q.size();
        return {exp_dout, exp_rdy, (n == 0), (n == DEPTH), (n >= PFT), exp_err, exp_ovf};
    endfunction

    // Drive one cycle of inputs, let the DUT clock, advance the model, settle.
    task automatic step(input logic v, input logic [9:0] d, input logic rd, input logic fl);
        logic [1:0] c;
        logic [7:0] p;
        logic       wr;
        logic [DOW-1:0] w;
        logic       e;
        @(negedge clk);
        bus.din_valid = v; bus.din = d; bus.rd_en = rd; bus.fifoFLUSH = fl;
        @(posedge clk);
        c = d[9:8]; p = d[7:0]; wr = 1'b0; w = '0; e = 1'b0;
        if (!rst) begin
            m_have_hi = 0; m_in_frame = 0; m_q.delete();
            exp_dout = '0; exp_rdy = 1'b0; exp_err = 1'b0; exp_ovf = 1'b0;
        end else begin
            if (v) begin
                if (!m_have_hi) begin
                    if (m_in_frame ? (c == 2'b10) : (c != 2'b11)) begin
                        e = 1'b1; m_in_frame = 0;
                    end else begin
                        m_have_hi = 1; m_hc = c; m_hi = p;
                    end
                end else begin
                    m_have_hi = 0;
                    case ({m_hc, c})
                        4'b1110: begin wr = 1'b1; w = {2'b10, m_hi, p}; e = m_in_frame; m_in_frame = 1; end
                        4'b1111: if (!m_in_frame) begin m_have_hi = 1; m_hi = p; end
                        4'b0000: begin wr = 1'b1; w = {2'b00, m_hi, p}; end
                        4'b0111: begin wr = 1'b1; w = {2'b01, m_hi, p}; m_in_frame = 0; end
                        default: begin e = 1'b1; m_in_frame = 0; end
                    endcase
                end
            end
            exp_err = e;
            exp_rdy = 1'b0;
            if (fl) begin
                m_q.delete(); exp_ovf = 1'b0;
            end else begin
                if (rd && m_q.size() > 0) begin exp_dout = m_q.pop_front(); exp_rdy = 1'b1; end
                if (wr) begin
                    if (m_q.size() < DEPTH) m_q.push_back(w);
                    else exp_ovf = 1'b1;
                end
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step(1'b0, 10'h000, 1'b0, 1'b0);
        rst = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        n_tests++;
        if (obs_vec() !== RESET_VEC) begin
            n_fail++; $display("FAIL reset_state: got %h want %h", obs_vec(), RESET_VEC);
        end
    endtask

    task automatic test_basic_frame();
        logic [9:0]     b [6] = '{10'h300, 10'h2AB, 10'h012, 10'h034, 10'h156, 10'h378};
        logic [DOW-1:0] wexp [3] = '{18'h200AB, 18'h01234, 18'h15678};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, b[i], 1'b0, 1'b0);
            n_tests++;
            if (obs_vec() !== exp_vec() || bus.err_proto !== 1'b0) begin
                n_fail++; $display("FAIL basic_byte%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 10'h000, 1'b1, 1'b0);
            n_tests++;
            if (bus.dout !== wexp[i] || bus.doutRdy !== 1'b1) begin
                n_fail++; $display("FAIL basic_word%0d: got %h rdy %b want %h", i, bus.dout, bus.doutRdy, wexp[i]);
            end
        end
        n_tests++;
        if (bus.empty !== 1'b1) begin
            n_fail++; $display("FAIL basic_empty: got %b want 1", bus.empty);
        end
    endtask

    task automatic test_comma_idle();
        logic [9:0]     b [15] = '{10'h300, 10'h300, 10'h300, 10'h300, 10'h300, 10'h2CD,
                                  10'h012, 10'h034, 10'h3FF, 10'h3FF, 10'h056, 10'h078,
                                  10'h3FF, 10'h3FF, 10'h1AA};
        logic [DOW-1:0] wexp [4] = '{18'h200CD, 18'h01234, 18'h05678, 18'h1AABB};
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, (i < 15) ? b[i] : 10'h3BB, 1'b0, 1'b0);
            n_tests++;
            if (obs_vec() !== exp_vec() || bus.err_proto !== 1'b0) begin
                n_fail++; $display("FAIL comma_byte%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 10'h000, 1'b1, 1'b0);
            n_tests++;
            if (i < 4 && (bus.dout !== wexp[i] || bus.doutRdy !== 1'b1)) begin
                n_fail++; $display("FAIL comma_word%0d: got %h rdy %b want %h", i, bus.dout, bus.doutRdy, wexp[i]);
            end else if (i == 4 && (bus.doutRdy !== 1'b0 || bus.empty !== 1'b1)) begin
                n_fail++; $display("FAIL comma_extra: rdy %b empty %b want 0 1", bus.doutRdy, bus.empty);
            end
        end
    endtask

    task automatic test_proto_err();
        logic [9:0]     b [6] = '{10'h300, 10'h2AB, 10'h012, 10'h156, 10'h300, 10'h201};
        logic           eexp [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [DOW-1:0] wexp [2] = '{18'h200AB, 18'h20001};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b1, b[i], 1'b0, 1'b0);
            n_tests++;
            if (bus.err_proto !== eexp[i] || obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL proto_byte%0d: err %b want %b, vec %h want %h",
                                   i, bus.err_proto, eexp[i], obs_vec(), exp_vec());
            end
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 10'h000, 1'b1, 1'b0);
            n_tests++;
            if (bus.dout !== wexp[i] || bus.doutRdy !== 1'b1) begin
                n_fail++; $display("FAIL proto_word%0d: got %h want %h", i, bus.dout, wexp[i]);
            end
        end
    endtask

    task automatic test_fill_overflow();
        logic [DOW-1:0] wv;
        do_reset();
        step(1'b1, 10'h300, 1'b0, 1'b0);
        for (int k = 1; k <= 17; k++) begin
            if (k == 1) step(1'b1, 10'h2C3, 1'b0, 1'b0);
            else begin
                step(1'b1, {2'b00, 8'(k)}, 1'b0, 1'b0);
                step(1'b1, {2'b00, 8'(k + 64)}, 1'b0, 1'b0);
            end
            n_tests++;
            if (bus.prog_full !== (k >= PFT) || bus.full !== (k >= DEPTH) ||
                bus.err_ovf !== (k >= 17) || obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL fill_word%0d: pf %b full %b ovf %b vec %h want %h",
                                   k, bus.prog_full, bus.full, bus.err_ovf, obs_vec(), exp_vec());
            end
        end
        for (int k = 1; k <= 16; k++) begin
            step(1'b0, 10'h000, 1'b1, 1'b0);
            wv = (k == 1) ? 18'h200C3 : {2'b00, 8'(k), 8'(k + 64)};
            n_tests++;
            if (bus.dout !== wv || bus.doutRdy !== 1'b1) begin
                n_fail++; $display("FAIL drain_word%0d: got %h want %h", k, bus.dout, wv);
            end
        end
        n_tests++;
        if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.err_ovf !== 1'b1) begin
            n_fail++; $display("FAIL drain_end: empty %b full %b ovf %b want 1 0 1", bus.empty, bus.full, bus.err_ovf);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        step(1'b1, 10'h300, 1'b0, 1'b0);
        step(1'b1, 10'h2C3, 1'b0, 1'b0);
        for (int k = 2; k <= 16; k++) begin
            step(1'b1, {2'b00, 8'(k)}, 1'b0, 1'b0);
            step(1'b1, {2'b00, 8'(k + 64)}, 1'b0, 1'b0);
        end
        // full: write and read on the same edge, occupancy holds 16
        step(1'b1, 10'h0A1, 1'b0, 1'b0);
        step(1'b1, 10'h0A2, 1'b1, 1'b0);
        n_tests++;
        if (bus.full !== 1'b1 || bus.doutRdy !== 1'b1 || bus.dout !== 18'h200C3 ||
            bus.err_ovf !== 1'b0 || obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL rw_full: full %b rdy %b dout %h ovf %b want 1 1 200c3 0",
                               bus.full, bus.doutRdy, bus.dout, bus.err_ovf);
        end
        step(1'b1, 10'h0B1, 1'b0, 1'b0);
        step(1'b1, 10'h0B2, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++) begin
            step(1'b0, 10'h000, 1'b1, 1'b0);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL rw_drain%0d: got %h want %h", k, obs_vec(), exp_vec());
            end
        end
        // empty: write and read on the same edge, read ignored, occupancy 1
        step(1'b1, 10'h0C1, 1'b1, 1'b0);
        step(1'b1, 10'h0C2, 1'b1, 1'b0);
        n_tests++;
        if (bus.empty !== 1'b0 || bus.doutRdy !== 1'b0 || bus.dout !== 18'h0A1A2 ||
            obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL rw_empty: empty %b rdy %b dout %h want 0 0 0a1a2",
                               bus.empty, bus.doutRdy, bus.dout);
        end
        for (int k = 0; k < 4; k++) begin
            step(1'b1, {2'b00, 8'(k)}, 1'b0, 1'b0);
            step(1'b1, {2'b00, 8'(k)}, 1'b0, 1'b0);
        end
        n_tests++;
        if (bus.err_ovf !== 1'b1 || bus.empty !== 1'b0) begin
            n_fail++; $display("FAIL pre_flush: ovf %b empty %b want 1 0", bus.err_ovf, bus.empty);
        end
        step(1'b0, 10'h000, 1'b1, 1'b1);
        n_tests++;
        if (bus.empty !== 1'b1 || bus.err_ovf !== 1'b0 || bus.doutRdy !== 1'b0 || obs_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL flush: empty %b ovf %b rdy %b want 1 0 0", bus.empty, bus.err_ovf, bus.doutRdy);
        end
        // FSM survives the flush: EOP still closes the frame
        step(1'b1, 10'h1EE, 1'b0, 1'b0);
        step(1'b1, 10'h3FF, 1'b1, 1'b0);
        step(1'b0, 10'h000, 1'b1, 1'b0);
        n_tests++;
        if (bus.dout !== 18'h1EEFF || bus.doutRdy !== 1'b1 || bus.err_proto !== 1'b0) begin
            n_fail++; $display("FAIL post_flush_eop: got %h rdy %b want 1eeff 1", bus.dout, bus.doutRdy);
        end
    endtask

    task automatic test_reset_mid_pair();
        do_reset();
        step(1'b1, 10'h300, 1'b0, 1'b0);
        step(1'b1, 10'h2AB, 1'b0, 1'b0);
        step(1'b0, 10'h000, 1'b1, 1'b0);
        step(1'b1, 10'h012, 1'b0, 1'b0);
        rst = 1'b0;
        step(1'b0, 10'h000, 1'b0, 1'b0);
        rst = 1'b1;
        n_tests++;
        if (obs_vec() !== RESET_VEC) begin
            n_fail++; $display("FAIL midpair_reset: got %h want %h", obs_vec(), RESET_VEC);
        end
        step(1'b1, 10'h034, 1'b0, 1'b0);
        n_tests++;
        if (bus.err_proto !== 1'b1 || bus.empty !== 1'b1) begin
            n_fail++; $display("FAIL midpair_lo: err %b empty %b want 1 1", bus.err_proto, bus.empty);
        end
    endtask

    task automatic test_random();
        logic [1:0] c;
        logic       v, rd, fl;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 85) begin
                if (!m_have_hi) begin
                    if (m_in_frame) c = ($urandom_range(0, 2) == 0) ? 2'b11 : 2'($urandom_range(0, 1));
                    else c = 2'b11;
                end else if (m_hc == 2'b11) begin
                    c = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11;
                end else begin
                    c = (m_hc == 2'b00) ? 2'b00 : 2'b11;
                end
            end else begin
                c = 2'($urandom_range(0, 3));
            end
            v  = ($urandom_range(0, 9) < 8);
            rd = (((i / 500) % 2) == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            fl = ($urandom_range(0, 149) == 0);
            rst = ($urandom_range(0, 699) == 0) ? 1'b0 : 1'b1;
            step(v, {c, 8'($urandom)}, rd, fl);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++; $display("FAIL random_cycle%0d: got %h want %h", i, obs_vec(), exp_vec());
            end
        end
        rst = 1'b1;
    endtask

    initial begin
        bus.din = 10'h000; bus.din_valid = 1'b0; bus.rd_en = 1'b0; bus.fifoFLUSH = 1'b0;
        test_reset();
        test_basic_frame();
        test_comma_idle();
        test_proto_err();
        test_fill_overflow();
        test_back_to_back();
        test_reset_mid_pair();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
